mem_access_ctrl: RTL and testbench

- Sequences the data-memory access of the MEM stage: takes access controls from the EX/MEM pipeline register and runs a req/ack transaction to data memory.
- Freezes the pipeline (Stall) for as long as the access is in flight.
- Generates byte enables and lane-aligned write data; extracts and extends load data for write-back.
- Flags misaligned accesses and memory timeouts.

---
 rtl/mem_access_ctrl.sv | 116 +++++++++++
 tb/tb_mem_access_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory req/ack sequencer with stall, lane steering and load extension
// Defining MEM_PERF_CNT_EN builds a saturating stall-cycle counter on StallCycles.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              MemReadIn,
  input  logic              MemWriteIn,
  input  logic [1:0]        bytes2LoadIn,
  input  logic [1:0]        bytes2StoreIn,
  input  logic              LoadSignedIn,
  input  logic [31:0]       ALUResultIn,
  input  logic [31:0]       StoreDataIn,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [3:0]        MemByteEn,
  output logic [31:0]       MemWData,
  input  logic              MemAck,
  input  logic [31:0]       MemRData,
  output logic              Stall,
  output logic [31:0]       LoadDataOut,
  output logic              LoadValid,
  output logic              MisalignErr,
  output logic              BusErr,
  output logic [31:0]       StallCycles
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  state_t state;
  logic [7:0] cnt;
  logic is_load, ld_signed;
  logic [1:0] ld_size, ld_off;
  logic access, aligned;
  logic [1:0] size, a;
  logic [3:0] be;
  logic [31:0] wdata, ext;
  logic [15:0] sh;
  always_comb begin
    access = MemReadIn | MemWriteIn;
    size = MemWriteIn ? bytes2StoreIn : bytes2LoadIn;
    a = ALUResultIn[1:0];
    aligned = size == 2'b10 || (size == 2'b01 ? !a[0] : a == 2'b00);
    be = size == 2'b10 ? 4'b0001 << a : size == 2'b01 ? 4'b0011 << a : 4'b1111;
    wdata = size == 2'b10 ? {4{StoreDataIn[7:0]}} : size == 2'b01 ? {2{StoreDataIn[15:0]}} : StoreDataIn;
    sh = 16'(MemRData >> {ld_off, 3'b000});
    ext = ld_size == 2'b10 ? {{24{ld_signed & sh[7]}}, sh[7:0]} :
          ld_size == 2'b01 ? {{16{ld_signed & sh[15]}}, sh} : MemRData;
  end
  // Gated with Rst_n so a reset drops the stall at once even while EX/MEM still holds the access
  assign Stall = Rst_n && (state == BUSY || (state == IDLE && access && aligned));
  assign MisalignErr = Rst_n && state == IDLE && access && !aligned;
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      cnt <= '0;
      MemReq <= 1'b0;
      MemWe <= 1'b0;
      MemAddr <= '0;
      MemByteEn <= '0;
      MemWData <= '0;
      LoadDataOut <= '0;
      LoadValid <= 1'b0;
      BusErr <= 1'b0;
      is_load <= 1'b0;
      ld_signed <= 1'b0;
      ld_size <= '0;
      ld_off <= '0;
    end else begin
      LoadValid <= 1'b0;
      BusErr <= 1'b0;
      case (state)
        IDLE: if (access && aligned) begin
          MemAddr <= {ALUResultIn[ADDR_W-1:2], 2'b00};
          MemWe <= MemWriteIn;
          MemByteEn <= be;
          MemWData <= wdata;
          is_load <= !MemWriteIn;
          ld_size <= size;
          ld_off <= a;
          ld_signed <= LoadSignedIn;
          MemReq <= 1'b1;
          cnt <= '0;
          state <= BUSY;
        end
        BUSY: if (MemAck) begin
          MemReq <= 1'b0;
          LoadValid <= is_load;
          if (is_load) LoadDataOut <= ext;
          state <= DONE;
        end else if (cnt == TMO_LAST) begin
          MemReq <= 1'b0;
          BusErr <= 1'b1;
          LoadValid <= is_load;
          if (is_load) LoadDataOut <= '0;
          state <= DONE;
        end else cnt <= cnt + 8'd1;
        DONE: begin
          cnt <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef MEM_PERF_CNT_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) StallCycles <= '0;
    else if (Stall && StallCycles != '1) StallCycles <= StallCycles + 32'd1;
  end
`else
  assign StallCycles = '0;
`endif
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;
  localparam int TMO = 15;
`ifdef MEM_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic Clk = 1'b0, Rst_n = 1'b0;
  logic MemReadIn = 0, MemWriteIn = 0, LoadSignedIn = 0, MemAck = 0;
  logic [1:0] bytes2LoadIn = 0, bytes2StoreIn = 0;
  logic [31:0] ALUResultIn = 0, StoreDataIn = 0, MemRData = 0;
  logic MemReq, MemWe, Stall, LoadValid, MisalignErr, BusErr;
  logic [31:0] MemAddr, MemWData, LoadDataOut, StallCycles;
  logic [3:0] MemByteEn;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
    .bytes2LoadIn(bytes2LoadIn), .bytes2StoreIn(bytes2StoreIn), .LoadSignedIn(LoadSignedIn),
    .ALUResultIn(ALUResultIn), .StoreDataIn(StoreDataIn), .MemReq(MemReq), .MemWe(MemWe),
    .MemAddr(MemAddr), .MemByteEn(MemByteEn), .MemWData(MemWData), .MemAck(MemAck),
    .MemRData(MemRData), .Stall(Stall), .LoadDataOut(LoadDataOut), .LoadValid(LoadValid),
    .MisalignErr(MisalignErr), .BusErr(BusErr), .StallCycles(StallCycles)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;
    logic ld; logic [31:0] ldata; logic berr; int stalls;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int n_cmp = 0, n_err = 0, stall_run = 0, stall_total = 0;
  logic prev_req = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic wr, input logic [1:0] lsz, input logic [1:0] ssz,
                                 input logic sgn, input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [31:0] rdata, input int dly);
    exp_t e;
    logic [1:0] sz;
    logic [7:0] b;
    logic [15:0] h;
    int a;
    sz = wr ? ssz : lsz;
    a = int'(addr[1:0]);
    e.we = wr; e.addr = {addr[31:2], 2'b00}; e.ld = !wr; e.berr = dly < 0;
    e.stalls = dly < 0 ? 1 + TMO : dly + 2;
    case (sz)
      2'b10: begin
        e.be = 4'b0001 << a; e.wdata = {4{sdata[7:0]}};
        b = rdata[8*a +: 8];
        e.ldata = sgn ? {{24{b[7]}}, b} : {24'h0, b};
      end
      2'b01: begin
        e.be = a == 2 ? 4'b1100 : 4'b0011; e.wdata = {2{sdata[15:0]}};
        h = a == 2 ? rdata[31:16] : rdata[15:0];
        e.ldata = sgn ? {{16{h[15]}}, h} : {16'h0, h};
      end
      default: begin e.be = 4'hF; e.wdata = sdata; e.ldata = rdata; end
    endcase
    if (dly < 0) e.ldata = 32'h0;
    return e;
  endfunction

  // Monitor: a completed access shows as MemReq falling (the DONE cycle)
  initial forever begin
    @(negedge Clk);
    if (!Rst_n) begin
      prev_req = 1'b0; stall_run = 0; stall_total = 0;
    end else begin
      if (Stall) begin stall_run++; stall_total++; end
      if (prev_req && !MemReq) begin
        if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else begin
          mon_e = sb.pop_front();
          chk("we", MemWe, mon_e.we);
          chk("addr", MemAddr, mon_e.addr);
          chk("be", MemByteEn, mon_e.be);
          if (mon_e.we) chk("wdata", MemWData, mon_e.wdata);
          chk("lv", LoadValid, mon_e.ld);
          if (mon_e.ld) chk("ldata", LoadDataOut, mon_e.ldata);
          chk("berr", BusErr, mon_e.berr);
          chk("stalls", 32'(stall_run), 32'(mon_e.stalls));
        end
        stall_run = 0;
      end else if (LoadValid || BusErr) chk("stray_pulse", {LoadValid, BusErr}, 32'd0);
      prev_req = MemReq;
    end
  end

  // Called at posedge+1; dly<0 means memory never acks
  task automatic do_acc(input logic rd, input logic wr, input logic [1:0] lsz, input logic [1:0] ssz,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] rdata, input int dly);
    int w;
    sb.push_back(model(wr, lsz, ssz, sgn, addr, sdata, rdata, dly));
    MemReadIn = rd; MemWriteIn = wr; bytes2LoadIn = lsz; bytes2StoreIn = ssz;
    LoadSignedIn = sgn; ALUResultIn = addr; StoreDataIn = sdata; MemRData = rdata;
    w = 0;
    do begin @(posedge Clk); #1; w++; end while (!MemReq && w < 4);
    chk("req_rise", MemReq, 1);
    if (dly >= 0) begin
      repeat (dly) begin @(posedge Clk); #1; end
      MemAck = 1;
      @(posedge Clk); #1;
      MemAck = 0;
    end else begin
      w = 0;
      while (MemReq && w < TMO + 5) begin @(posedge Clk); #1; w++; end
    end
    chk("req_fall", MemReq, 0);
    MemReadIn = 0; MemWriteIn = 0;
    @(posedge Clk); #1;
    chk("stall_cycles", StallCycles, PERF ? 32'(stall_total) : 32'd0);
  endtask

  initial begin
    int w;
    logic [1:0] sz;
    logic [31:0] ad;
    repeat (2) @(negedge Clk);
    chk("rst_req", MemReq, 0);
    chk("rst_we", MemWe, 0);
    chk("rst_addr", MemAddr, 0);
    chk("rst_be", MemByteEn, 0);
    chk("rst_wdata", MemWData, 0);
    chk("rst_ldata", LoadDataOut, 0);
    chk("rst_flags", {Stall, LoadValid, MisalignErr, BusErr}, 0);
    chk("rst_stallcnt", StallCycles, 0);
    @(posedge Clk); #1 Rst_n = 1;
    @(posedge Clk); #1;

    do_acc(1, 0, 2'b00, 2'b00, 0, 32'h1000, 0, 32'hDEADBEEF, 0);
    chk("tp_word", LoadDataOut, 32'hDEADBEEF);
    do_acc(1, 0, 2'b10, 2'b00, 1, 32'h1003, 0, 32'h80FF1234, 0);
    chk("tp_sbyte", LoadDataOut, 32'hFFFFFF80);
    do_acc(1, 0, 2'b10, 2'b00, 0, 32'h1003, 0, 32'h80FF1234, 0);
    chk("tp_ubyte", LoadDataOut, 32'h00000080);
    do_acc(0, 1, 2'b00, 2'b01, 0, 32'h2002, 32'h0000ABCD, 0, 3);
    chk("tp_hstore", MemWData, 32'hABCDABCD);
    chk("tp_hold", LoadDataOut, 32'h00000080);
    do_acc(1, 1, 2'b00, 2'b10, 0, 32'h4001, 32'h12345678, 0, 1);
    do_acc(1, 0, 2'b11, 2'b00, 1, 32'h5004, 0, 32'h87654321, 2);
    do_acc(1, 0, 2'b01, 2'b00, 1, 32'h6002, 0, 32'h80017FFF, 0);
    chk("tp_shalf", LoadDataOut, 32'hFFFF8001);

    MemReadIn = 1; bytes2LoadIn = 2'b00; ALUResultIn = 32'h3001;
    #3;
    chk("mis_pulse", MisalignErr, 1);
    chk("mis_stall", Stall, 0);
    @(posedge Clk); #1;
    chk("mis_noreq", MemReq, 0);
    MemReadIn = 0; MemWriteIn = 1; bytes2StoreIn = 2'b01; ALUResultIn = 32'h2001;
    #3;
    chk("mis_hstore", MisalignErr, 1);
    MemWriteIn = 0;
    #1;
    chk("mis_clear", MisalignErr, 0);
    @(posedge Clk); #1;
    chk("mis_noreq2", MemReq, 0);

    do_acc(1, 0, 2'b00, 2'b00, 0, 32'h7000, 0, 32'hFFFFFFFF, -1);
    chk("tmo_data", LoadDataOut, 32'h0);
    chk("tmo_stall", Stall, 0);

    MemAck = 1; MemRData = 32'h55AA55AA;
    @(posedge Clk); #1 MemAck = 0;
    chk("idle_ack_req", MemReq, 0);
    chk("idle_ack_lv", LoadValid, 0);
    chk("idle_ack_stall", Stall, 0);

    for (int i = 0; i < 16; i++) begin
      sz = 2'($urandom_range(0, 3));
      ad = $urandom & 32'hFFFF_FFFC;
      if (sz == 2'b10) ad[1:0] = 2'($urandom_range(0, 3));
      else if (sz == 2'b01) ad[1] = 1'($urandom_range(0, 1));
      do_acc(1, 1'($urandom_range(0, 1)), sz, sz, 1'($urandom_range(0, 1)), ad, $urandom, $urandom,
             int'($urandom_range(0, 3)));
    end

    MemReadIn = 1; bytes2LoadIn = 2'b00; ALUResultIn = 32'h8000;
    w = 0;
    do begin @(posedge Clk); #1; w++; end while (!MemReq && w < 4);
    chk("rst_mid_req", MemReq, 1);
    @(posedge Clk); #2 Rst_n = 0;
    #1;
    chk("rst_mid_drop", MemReq, 0);
    chk("rst_mid_stall", Stall, 0);
    MemReadIn = 0;
    @(posedge Clk); #1 Rst_n = 1;
    @(posedge Clk); #1;
    chk("rst_noretry", MemReq, 0);
    chk("rst_cnt", StallCycles, 0);
    do_acc(1, 0, 2'b00, 2'b00, 0, 32'h9000, 0, 32'hCAFEF00D, 1);
    chk("post_rst", LoadDataOut, 32'hCAFEF00D);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
